line_tx_arbiter: RTL and testbench
==================================

LINE_TX_ARBITER -- requirements
Module: line_tx_arbiter

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4352, meaning bytes per frame (4 rows x 1088 columns), legal range 4..4352.
REQ-002 SHALL have parameter PEND_MAX, default 3, meaning the saturation value of the pending-retransmit count.
REQ-003 SHALL have ports: i_clk  in  1  the single clock; i_rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have new-frame source ports: i_map_data in 8; i_map_valid in 1; i_map_fas in 1 (first byte of frame); o_map_ready out 1.
REQ-005 SHALL have retransmit source ports (record FIFO): i_rec_data in 8; i_rec_valid in 1; i_rec_fas in 1; o_rec_ready out 1.
REQ-006 SHALL have line sink ports: o_line_data out 8; o_line_valid out 1; o_line_fas out 1; i_line_ready in 1.
REQ-007 SHALL have control ports: i_line_retrans_req in 1 (single-cycle request); o_retx_active out 1; o_align_err out 1 (pulse); o_retx_ovf out 1 (pulse).
REQ-008 SHALL have stats ports: o_new_frm_cnt out 16; o_retx_frm_cnt out 16.

Function
REQ-009 SHALL implement an FSM with states IDLE, SEND_NEW, SEND_RETX.
REQ-010 A transfer on a port SHALL occur only in a cycle where that port's valid and ready are both high.
REQ-011 In IDLE, if pending>0 and i_rec_valid=1, the FSM SHALL select the retransmit source; else if i_map_valid=1, the new source; else it SHALL stay in IDLE.
REQ-012 Retransmit SHALL have strict priority over new data, evaluated only in IDLE (frame boundaries); a frame in progress is never preempted.
REQ-013 In IDLE, the selected source SHALL pass through combinationally in the same cycle, with zero latency, if its fas=1.
REQ-014 In IDLE, a selected byte with fas=0 SHALL be discarded by asserting that source's ready, keeping o_line_valid=0 and pulsing o_align_err for one cycle.
REQ-015 In SEND_NEW and SEND_RETX, o_line_* SHALL mirror the selected source, with source ready = i_line_ready and the unselected ready held 0.
REQ-016 An 13-bit byte counter SHALL increment on each line transfer; on the transfer where count=FRAME_LEN-1 it SHALL clear and the FSM SHALL return to IDLE.
REQ-017 A line transfer with fas=1 at count!=0 SHALL pulse o_align_err and SHALL still be forwarded; the count is unaffected.
REQ-018 The pending count SHALL increment on i_line_retrans_req and decrement on the IDLE->SEND_RETX transition; if both occur in one cycle it SHALL be unchanged.
REQ-019 When pending=PEND_MAX and a request arrives without a simultaneous decrement, pending SHALL hold and o_retx_ovf SHALL pulse for one cycle.
REQ-020 o_retx_active SHALL be 1 in SEND_RETX and in any cycle when pending>0.
REQ-021 With i_line_ready=0 mid-frame, the state and count SHALL hold; o_line_valid SHALL follow the source valid and SHALL not be masked.

Reset
REQ-022 On i_rst_n low the block SHALL enter IDLE asynchronously, with count, pending and stats set to 0, and all outputs 0.
REQ-023 On reset mid-frame the partial frame SHALL be abandoned; after release, the source bytes are handled per REQ-014 until the next fas.
REQ-024 Reset release SHALL be synchronous to i_clk, with the first transfer possible in the first cycle after release.

Configuration
REQ-025 Macro LINE_ARB_STATS_EN defined: o_new_frm_cnt and o_retx_frm_cnt SHALL each increment by 1, wrapping at 16 bits, on every completed frame of their type.
REQ-026 Macro LINE_ARB_STATS_EN undefined: both stats outputs SHALL be constant 0 with no counter registers.

Structure
REQ-027 The shared package line_pkg SHALL hold FRAME_LEN default, state encoding typedef, and counter width constants.
REQ-028 The frame byte counter and its end-of-frame flag SHALL be a sub-module, frame_byte_cnt.

Verification (FRAME_LEN=8)
REQ-029 Continuous valid new frames with fas on byte 0, i_line_ready=1 -> 8 bytes per frame, back-to-back, o_map_ready=1 throughout, new count increments per frame.
REQ-030 Request pulsed at byte 3 of a new frame, record FIFO valid -> new frame completes, next frame from rec source, pending 1->0, o_map_ready=0 during it.
REQ-031 Four requests in idle with PEND_MAX=3 -> pending=3, one o_retx_ovf pulse, three retransmit frames sent before any new frame.
REQ-032 Request and IDLE->SEND_RETX in the same cycle -> pending unchanged.
REQ-033 Source presents 2 bytes with fas=0 then a fas=1 frame -> 2 discards, 2 o_align_err pulses, then a normal 8-byte frame.
REQ-034 i_line_ready toggled 0/1 mid-frame, then i_rst_n asserted at byte 5 -> no byte duplicated or lost before reset, IDLE immediately, all outputs 0.

Source files
------------

// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared constants and state encoding for the line transmit arbiter
package line_pkg;

  localparam int FRAME_LEN_DEF = 4352;
  localparam int CNT_W         = 13;
  localparam int PEND_W        = 8;
  localparam int STAT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND_NEW  = 2'd1,
    ST_SEND_RETX = 2'd2
  } state_t;

endpackage

// File: rtl/frame_byte_cnt.sv
// rtl/frame_byte_cnt.sv - per-frame byte position counter with first/last byte flags
module frame_byte_cnt
  import line_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic first,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] count;

  assign first = (count == '0);
  assign last  = (count == LAST_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/line_tx_arbiter.sv
// rtl/line_tx_arbiter.sv - frame-aligned arbiter between new-frame and retransmit sources
// Per-type completed-frame counters exist only when LINE_ARB_STATS_EN is defined.
module line_tx_arbiter
  import line_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int PEND_MAX  = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_map_data,
  input  logic        i_map_valid,
  input  logic        i_map_fas,
  output logic        o_map_ready,
  input  logic [7:0]  i_rec_data,
  input  logic        i_rec_valid,
  input  logic        i_rec_fas,
  output logic        o_rec_ready,
  output logic [7:0]  o_line_data,
  output logic        o_line_valid,
  output logic        o_line_fas,
  input  logic        i_line_ready,
  input  logic        i_line_retrans_req,
  output logic        o_retx_active,
  output logic        o_align_err,
  output logic        o_retx_ovf,
  output logic [15:0] o_new_frm_cnt,
  output logic [15:0] o_retx_frm_cnt
);

  localparam logic [PEND_W-1:0] PEND_SAT = PEND_W'(PEND_MAX);

  state_t            state;
  state_t            state_nxt;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pending_nxt;

  logic       use_rec;
  logic       src_valid;
  logic       src_fas;
  logic [7:0] src_data;
  logic       src_ready;
  logic [7:0] line_data;
  logic       line_valid;
  logic       line_fas;
  logic       line_xfer;
  logic       align_err;
  logic       retx_start;
  logic       retx_ovf;
  logic       cnt_first;
  logic       cnt_last;

  // Source choice is only re-evaluated in IDLE; inside a frame the state pins it.
  assign use_rec   = (state == ST_SEND_RETX) ||
                     ((state == ST_IDLE) && (pending != '0) && i_rec_valid);
  assign src_valid = use_rec ? i_rec_valid : i_map_valid;
  assign src_fas   = use_rec ? i_rec_fas   : i_map_fas;
  assign src_data  = use_rec ? i_rec_data  : i_map_data;

  always_comb begin
    state_nxt  = state;
    line_data  = '0;
    line_valid = 1'b0;
    line_fas   = 1'b0;
    src_ready  = 1'b0;
    line_xfer  = 1'b0;
    align_err  = 1'b0;
    retx_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (src_valid) begin
          if (src_fas) begin
            line_data  = src_data;
            line_valid = 1'b1;
            line_fas   = 1'b1;
            src_ready  = i_line_ready;
            line_xfer  = i_line_ready;
            if (i_line_ready) begin
              state_nxt  = use_rec ? ST_SEND_RETX : ST_SEND_NEW;
              retx_start = use_rec;
            end
          end else begin
            // Misaligned byte: drop it so the source can advance to the next fas.
            src_ready = 1'b1;
            align_err = 1'b1;
          end
        end
      end
      ST_SEND_NEW, ST_SEND_RETX: begin
        line_data  = src_data;
        line_valid = src_valid;
        line_fas   = src_fas;
        src_ready  = i_line_ready;
        line_xfer  = src_valid && i_line_ready;
        if (line_xfer && src_fas && !cnt_first) begin
          align_err = 1'b1;
        end
        if (line_xfer && cnt_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    pending_nxt = pending;
    retx_ovf    = 1'b0;
    if (i_line_retrans_req && !retx_start) begin
      if (pending == PEND_SAT) begin
        retx_ovf = 1'b1;
      end else begin
        pending_nxt = pending + 1'b1;
      end
    end else if (!i_line_retrans_req && retx_start) begin
      pending_nxt = pending - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  frame_byte_cnt #(
    .FRAME_LEN(FRAME_LEN)
  ) u_cnt (
    .clk  (i_clk),
    .rst_n(i_rst_n),
    .inc  (line_xfer),
    .first(cnt_first),
    .last (cnt_last)
  );

  // Combinational paths are forced low while reset is held.
  assign o_line_data   = i_rst_n ? line_data : 8'h00;
  assign o_line_valid  = i_rst_n && line_valid;
  assign o_line_fas    = i_rst_n && line_fas;
  assign o_map_ready   = i_rst_n && src_ready && !use_rec;
  assign o_rec_ready   = i_rst_n && src_ready && use_rec;
  assign o_align_err   = i_rst_n && align_err;
  assign o_retx_ovf    = i_rst_n && retx_ovf;
  assign o_retx_active = i_rst_n && ((state == ST_SEND_RETX) || (pending != '0));

`ifdef LINE_ARB_STATS_EN
  logic              done_new;
  logic              done_retx;
  logic [STAT_W-1:0] new_cnt;
  logic [STAT_W-1:0] retx_cnt;

  assign done_new  = line_xfer && cnt_last && (state == ST_SEND_NEW);
  assign done_retx = line_xfer && cnt_last && (state == ST_SEND_RETX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      new_cnt  <= '0;
      retx_cnt <= '0;
    end else begin
      if (done_new) begin
        new_cnt <= new_cnt + 1'b1;
      end
      if (done_retx) begin
        retx_cnt <= retx_cnt + 1'b1;
      end
    end
  end

  assign o_new_frm_cnt  = new_cnt;
  assign o_retx_frm_cnt = retx_cnt;
`else
  assign o_new_frm_cnt  = '0;
  assign o_retx_frm_cnt = '0;
`endif

endmodule

// File: tb/tb_line_tx_arbiter.sv
// tb/tb_line_tx_arbiter.sv - directed and randomized checks of line_tx_arbiter with FRAME_LEN=8
module tb_line_tx_arbiter;

  localparam int FL = 8;
  localparam int PM = 3;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_map_data = '0;
  logic        i_map_valid = 1'b0;
  logic        i_map_fas = 1'b0;
  logic        o_map_ready;
  logic [7:0]  i_rec_data = '0;
  logic        i_rec_valid = 1'b0;
  logic        i_rec_fas = 1'b0;
  logic        o_rec_ready;
  logic [7:0]  o_line_data;
  logic        o_line_valid;
  logic        o_line_fas;
  logic        i_line_ready = 1'b0;
  logic        i_line_retrans_req = 1'b0;
  logic        o_retx_active;
  logic        o_align_err;
  logic        o_retx_ovf;
  logic [15:0] o_new_frm_cnt;
  logic [15:0] o_retx_frm_cnt;

  always #5 i_clk = ~i_clk;

  line_tx_arbiter #(
    .FRAME_LEN(FL),
    .PEND_MAX (PM)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_map_data        (i_map_data),
    .i_map_valid       (i_map_valid),
    .i_map_fas         (i_map_fas),
    .o_map_ready       (o_map_ready),
    .i_rec_data        (i_rec_data),
    .i_rec_valid       (i_rec_valid),
    .i_rec_fas         (i_rec_fas),
    .o_rec_ready       (o_rec_ready),
    .o_line_data       (o_line_data),
    .o_line_valid      (o_line_valid),
    .o_line_fas        (o_line_fas),
    .i_line_ready      (i_line_ready),
    .i_line_retrans_req(i_line_retrans_req),
    .o_retx_active     (o_retx_active),
    .o_align_err       (o_align_err),
    .o_retx_ovf        (o_retx_ovf),
    .o_new_frm_cnt     (o_new_frm_cnt),
    .o_retx_frm_cnt    (o_retx_frm_cnt)
  );

  // Source queues hold {fas, data}; map data has bit 7 clear, record data has it set.
  logic [8:0] map_q[$];
  logic [8:0] rec_q[$];
  logic [8:0] out_q[$];
  logic [8:0] exp_q[$];

  int tests = 0;
  int fails = 0;
  int align_cnt = 0;
  int ovf_cnt = 0;
  int exp_new = 0;
  int exp_retx = 0;
  bit rdy_rand = 1'b0;
  bit map_gap = 1'b0;
  bit chk_map_rdy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    i_map_valid = (map_q.size() != 0) && !(map_gap && ($urandom_range(0, 3) == 0));
    {i_map_fas, i_map_data} = (map_q.size() != 0) ? map_q[0] : 9'h000;
    i_rec_valid = (rec_q.size() != 0);
    {i_rec_fas, i_rec_data} = (rec_q.size() != 0) ? rec_q[0] : 9'h000;
    i_line_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    @(negedge i_clk);
    if (o_line_valid && i_line_ready) out_q.push_back({o_line_fas, o_line_data});
    if (o_align_err) align_cnt++;
    if (o_retx_ovf) ovf_cnt++;
    if (chk_map_rdy) check("map_ready_cont", o_map_ready, 1);
    if (o_line_valid && o_line_data[7]) begin
      check("map_ready_in_retx", o_map_ready, 0);
      check("active_in_retx", o_retx_active, 1);
    end
    if (i_map_valid && o_map_ready) void'(map_q.pop_front());
    if (i_rec_valid && o_rec_ready) void'(rec_q.pop_front());
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_frame(input bit rec, input bit to_exp, input int extra_fas);
    logic [8:0] b;
    for (int i = 0; i < FL; i++) begin
      b = {((i == 0) || (i == extra_fas)), rec, 7'($urandom)};
      if (rec) rec_q.push_back(b);
      else map_q.push_back(b);
      if (to_exp) exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (map_q.size() == 0 && rec_q.size() == 0) break;
      cyc();
    end
    check(tag, map_q.size() + rec_q.size(), 0);
  endtask

  task automatic cmp_out(input string tag);
    int n;
    check({tag, "_len"}, out_q.size(), exp_q.size());
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check(tag, out_q[i], exp_q[i]);
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stats(input string tag);
`ifdef LINE_ARB_STATS_EN
    check({tag, "_new"}, o_new_frm_cnt, exp_new);
    check({tag, "_retx"}, o_retx_frm_cnt, exp_retx);
`else
    check({tag, "_new"}, o_new_frm_cnt, 0);
    check({tag, "_retx"}, o_retx_frm_cnt, 0);
`endif
  endtask

  initial begin
    // Reset held with a valid aligned byte presented: everything stays quiet.
    repeat (2) @(posedge i_clk);
    #1;
    i_map_valid = 1'b1; i_map_fas = 1'b1; i_map_data = 8'h5a; i_line_ready = 1'b1;
    @(negedge i_clk);
    check("rst_line_valid", o_line_valid, 0);
    check("rst_line_data", o_line_data, 0);
    check("rst_map_ready", o_map_ready, 0);
    @(posedge i_clk);
    #1;
    i_map_valid = 1'b0; i_map_fas = 1'b0; i_map_data = 8'h00; i_line_ready = 1'b0;
    i_rst_n = 1'b1;
    #1;
    check("idle_line_valid", o_line_valid, 0);
    check("idle_ready", {o_map_ready, o_rec_ready}, 0);
    check("idle_flags", {o_retx_active, o_align_err, o_retx_ovf}, 0);
    check_stats("idle_stats");

    // Back-to-back new frames at full rate, first byte right after release.
    push_frame(1'b0, 1'b1, -1);
    push_frame(1'b0, 1'b1, -1);
    push_frame(1'b0, 1'b1, -1);
    chk_map_rdy = 1'b1;
    drain("t1_drain", 3 * FL);
    chk_map_rdy = 1'b0;
    cmp_out("t1_out");
    exp_new += 3;
    check_stats("t1_stats");

    // Random valid gaps and line back-pressure; one frame carries a stray fas.
    rdy_rand = 1'b1; map_gap = 1'b1; align_cnt = 0;
    push_frame(1'b0, 1'b1, -1);
    push_frame(1'b0, 1'b1, 5);
    push_frame(1'b0, 1'b1, -1);
    push_frame(1'b0, 1'b1, -1);
    drain("t1b_drain", 400);
    cmp_out("t1b_out");
    check("t1b_align", align_cnt, 1);
    exp_new += 4;
    rdy_rand = 1'b0; map_gap = 1'b0;

    // Retransmit request mid-frame waits for the frame boundary.
    push_frame(1'b0, 1'b1, -1);
    push_frame(1'b1, 1'b1, -1);
    push_frame(1'b0, 1'b1, -1);
    repeat (3) cyc();
    i_line_retrans_req = 1'b1;
    cyc();
    i_line_retrans_req = 1'b0;
    check("t2_active", o_retx_active, 1);
    drain("t2_drain", 3 * FL - 4);
    cmp_out("t2_out");
    check("t2_active_end", o_retx_active, 0);
    exp_new += 2; exp_retx += 1;
    check_stats("t2_stats");

    // Four requests saturate at three; three retransmits precede new data.
    ovf_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      i_line_retrans_req = 1'b1;
      cyc();
      check("t3_ovf", ovf_cnt, (r == 3) ? 1 : 0);
    end
    i_line_retrans_req = 1'b0;
    check("t3_active", o_retx_active, 1);
    push_frame(1'b1, 1'b1, -1);
    push_frame(1'b1, 1'b1, -1);
    push_frame(1'b1, 1'b1, -1);
    push_frame(1'b0, 1'b1, -1);
    drain("t3_drain", 4 * FL);
    cmp_out("t3_out");
    check("t3_active_end", o_retx_active, 0);
    exp_retx += 3; exp_new += 1;

    // Request coinciding with the retransmit start leaves pending unchanged.
    ovf_cnt = 0;
    i_line_retrans_req = 1'b1;
    cyc();
    push_frame(1'b1, 1'b1, -1);
    cyc();
    i_line_retrans_req = 1'b0;
    drain("t4_drain", FL);
    cmp_out("t4_out");
    check("t4_ovf", ovf_cnt, 0);
    check("t4_still_pending", o_retx_active, 1);
    push_frame(1'b1, 1'b1, -1);
    drain("t4b_drain", FL);
    cmp_out("t4b_out");
    check("t4_active_end", o_retx_active, 0);
    exp_retx += 2;
    check_stats("t4_stats");

    // Two leading misaligned bytes are dropped before the real frame.
    align_cnt = 0;
    map_q.push_back({1'b0, 1'b0, 7'h11});
    map_q.push_back({1'b0, 1'b0, 7'h22});
    push_frame(1'b0, 1'b1, -1);
    drain("t5_drain", 2 + FL);
    cmp_out("t5_out");
    check("t5_align", align_cnt, 2);
    exp_new += 1;

    // Back-pressured frame cut by reset after five bytes; tail is then discarded.
    rdy_rand = 1'b1;
    push_frame(1'b0, 1'b0, -1);
    for (int i = 0; i < 5; i++) exp_q.push_back(map_q[i]);
    for (int k = 0; k < 200 && out_q.size() < 5; k++) cyc();
    cmp_out("t6_pre");
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_line", {o_line_valid, o_line_fas, o_line_data}, 0);
    check("t6_rst_ready", {o_map_ready, o_rec_ready}, 0);
    check("t6_rst_flags", {o_retx_active, o_align_err, o_retx_ovf}, 0);
    exp_new = 0; exp_retx = 0;
    check_stats("t6_rst_stats");
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    rdy_rand = 1'b0;
    align_cnt = 0;
    push_frame(1'b0, 1'b1, -1);
    drain("t6_drain", 3 + FL);
    cmp_out("t6_out");
    check("t6_align", align_cnt, 3);
    exp_new += 1;
    check_stats("t6_stats");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
